mt_1rw_bank_resp: RTL and testbench

- Cycle-accurate responder model of one physical 1RW bank behind the multi-port bank mux.
- Accepts the mux-side t1 request signals for one bank/port slot: read, write, refresh.
- Returns read data together with forwarding, single-error, double-error and physical-row status after a fixed DRAM_DELAY pipeline.
- Models protocol violations (collisions, access during refresh) and error injection for mux verification.

---
 rtl/mt_1rw_bank_resp_if.sv | 37 +++
 rtl/mt_1rw_bank_resp.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_mt_1rw_bank_resp.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mt_1rw_bank_resp_if.sv
// Mux-side request/response bundle for one 1RW bank slot.
// The mux (master) drives requests; the bank responder (slave) returns data/status.
interface mt_1rw_bank_resp_if #(
    parameter int WIDTH   = 32,
    parameter int BITVROW = 10,
    parameter int BITPADR = 14,
    parameter int BITPBNK = 4
);
    // requests
    logic                       readA;
    logic                       writeA;
    logic [BITVROW-1:0]         addrA;
    logic [WIDTH-1:0]           dinA;
    logic                       refrB;
    logic                       inj_s;
    logic                       inj_d;

    // responses / status
    logic [WIDTH-1:0]           doutA;
    logic                       dvldA;
    logic                       fwrdA;
    logic                       serrA;
    logic                       derrA;
    logic [BITPADR-BITPBNK-1:0] padrA;
    logic                       busyA;
    logic                       collA;

    modport master (
        output readA, writeA, addrA, dinA, refrB, inj_s, inj_d,
        input  doutA, dvldA, fwrdA, serrA, derrA, padrA, busyA, collA
    );

    modport slave (
        input  readA, writeA, addrA, dinA, refrB, inj_s, inj_d,
        output doutA, dvldA, fwrdA, serrA, derrA, padrA, busyA, collA
    );
endinterface

// File: rtl/mt_1rw_bank_resp.sv
// Cycle-accurate responder for one physical 1RW bank slot.
// Writes pass through a one-entry write stage before committing to the array;
// reads look up the array (or forward from the write stage) and return after
// DRAM_DELAY cycles with forwarding, error-injection and physical-row status.
// Refresh occupies the bank for REFR_CYC cycles; protocol violations are
// dropped and latched in a sticky collision flag.
module mt_1rw_bank_resp #(
    parameter int WIDTH      = 32,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = 10,
    parameter int BITPADR    = 14,
    parameter int BITPBNK    = 4,
    parameter int DRAM_DELAY = 2,
    parameter int REFR_CYC   = 4
) (
    input  logic                    clk,
    input  logic                    rst,   // asynchronous, active low
    mt_1rw_bank_resp_if.slave       bus
);
    localparam int PADRW = BITPADR - BITPBNK;
    localparam int CNTW  = (REFR_CYC > 1) ? $clog2(REFR_CYC) : 1;

    // One returned read, already resolved (forwarding, error flags, corruption).
    typedef struct packed {
        logic             vld;
        logic             fwd;
        logic             serr;
        logic             derr;
        logic [PADRW-1:0] padr;
        logic [WIDTH-1:0] data;
    } resp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REFR = 1'b1
    } refr_state_t;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic busy_q;
    logic req_any;
    logic addr_ok;
    logic refr_start;
    logic viol;
    logic rd_acc;
    logic wr_acc;

    // Decide which requests are accepted this cycle and which are violations.
    // A refresh accepted from idle still starts even if it collides with an access.
    always_comb begin
        req_any    = bus.readA | bus.writeA;
        addr_ok    = ({1'b0, bus.addrA} < (BITVROW+1)'(NUMVROW));
        refr_start = bus.refrB & ~busy_q;
        viol       = (bus.readA & bus.writeA)
                   | (req_any & (busy_q | refr_start))
                   | (req_any & ~addr_ok);
        rd_acc     = bus.readA  & ~viol;
        wr_acc     = bus.writeA & ~viol;
    end

    // ------------------------------------------------------------------
    // Sticky collision flag
    // ------------------------------------------------------------------
    logic coll_q;
    logic coll_d;

    // Any violation latches the flag until reset.
    always_comb begin
        coll_d = coll_q | viol;
    end

    // Collision flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    // ------------------------------------------------------------------
    // Refresh state machine
    // ------------------------------------------------------------------
    refr_state_t     state_q;
    logic [CNTW-1:0] cnt_q;

    // IDLE -> REFR on refrB, stay busy REFR_CYC cycles; refrB while busy is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.refrB) begin
                        state_q <= ST_REFR;
                        cnt_q   <= CNTW'(REFR_CYC - 1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_REFR: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write stage: holds the write accepted last cycle until it commits
    // ------------------------------------------------------------------
    logic               ws_vld_q,  ws_vld_d;
    logic [BITVROW-1:0] ws_addr_q, ws_addr_d;
    logic [WIDTH-1:0]   ws_data_q, ws_data_d;
    logic               ws_s_q,    ws_s_d;
    logic               ws_d_q,    ws_d_d;

    // Capture an accepted write; the entry lives for exactly one cycle.
    always_comb begin
        ws_vld_d  = wr_acc;
        ws_addr_d = ws_addr_q;
        ws_data_d = ws_data_q;
        ws_s_d    = ws_s_q;
        ws_d_d    = ws_d_q;
        if (wr_acc) begin
            ws_addr_d = bus.addrA;
            ws_data_d = bus.dinA;
            ws_s_d    = bus.inj_s;
            ws_d_d    = bus.inj_d;
        end
    end

    // Write stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ws_vld_q  <= 1'b0;
            ws_addr_q <= '0;
            ws_data_q <= '0;
            ws_s_q    <= 1'b0;
            ws_d_q    <= 1'b0;
        end else begin
            ws_vld_q  <= ws_vld_d;
            ws_addr_q <= ws_addr_d;
            ws_data_q <= ws_data_d;
            ws_s_q    <= ws_s_d;
            ws_d_q    <= ws_d_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-row error flags (cleared on reset, rewritten on every commit)
    // ------------------------------------------------------------------
    logic [NUMVROW-1:0] serr_map_q, serr_map_d;
    logic [NUMVROW-1:0] derr_map_q, derr_map_d;

    // A committing write replaces the row's flags with its injection bits.
    always_comb begin
        serr_map_d = serr_map_q;
        derr_map_d = derr_map_q;
        if (ws_vld_q) begin
            serr_map_d[ws_addr_q] = ws_s_q;
            derr_map_d[ws_addr_q] = ws_d_q;
        end
    end

    // Error flag bitmap registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serr_map_q <= '0;
            derr_map_q <= '0;
        end else begin
            serr_map_q <= serr_map_d;
            derr_map_q <= derr_map_d;
        end
    end

    // ------------------------------------------------------------------
    // Data array: registered read, write from the write stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [NUMVROW];
    logic [WIDTH-1:0] mem_rd_q;

    // The read sees pre-commit contents; a same-row commit is covered by forwarding.
    always_ff @(posedge clk) begin
        if (ws_vld_q) begin
            mem[ws_addr_q] <= ws_data_q;
        end
        if (rd_acc) begin
            mem_rd_q <= mem[bus.addrA];
        end
    end

    // ------------------------------------------------------------------
    // First read stage: side information travelling with the array read
    // ------------------------------------------------------------------
    logic               s1_vld_q,   s1_vld_d;
    logic               s1_fwd_q,   s1_fwd_d;
    logic               s1_serr_q,  s1_serr_d;
    logic               s1_derr_q,  s1_derr_d;
    logic [BITVROW-1:0] s1_addr_q,  s1_addr_d;
    logic [WIDTH-1:0]   s1_wdata_q, s1_wdata_d;

    // Forward from the write stage when it holds the row being read.
    always_comb begin
        s1_vld_d   = rd_acc;
        s1_fwd_d   = rd_acc & ws_vld_q & (ws_addr_q == bus.addrA);
        s1_wdata_d = ws_data_q;
        s1_addr_d  = bus.addrA;
        s1_serr_d  = 1'b0;
        s1_derr_d  = 1'b0;
        if (rd_acc) begin
            s1_serr_d = s1_fwd_d ? ws_s_q : serr_map_q[bus.addrA];
            s1_derr_d = s1_fwd_d ? ws_d_q : derr_map_q[bus.addrA];
        end
    end

    // First read stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q   <= 1'b0;
            s1_fwd_q   <= 1'b0;
            s1_serr_q  <= 1'b0;
            s1_derr_q  <= 1'b0;
            s1_addr_q  <= '0;
            s1_wdata_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_fwd_q   <= s1_fwd_d;
            s1_serr_q  <= s1_serr_d;
            s1_derr_q  <= s1_derr_d;
            s1_addr_q  <= s1_addr_d;
            s1_wdata_q <= s1_wdata_d;
        end
    end

    resp_t s1_resp;

    // Resolve the return: double error wins, clears serr and flips data bit 0.
    // Idle slots are forced to all-zero.
    always_comb begin
        s1_resp = '0;
        if (s1_vld_q) begin
            s1_resp.vld  = 1'b1;
            s1_resp.fwd  = s1_fwd_q;
            s1_resp.derr = s1_derr_q;
            s1_resp.serr = s1_serr_q & ~s1_derr_q;
            s1_resp.padr = PADRW'(s1_addr_q);
            s1_resp.data = (s1_fwd_q ? s1_wdata_q : mem_rd_q)
                         ^ {{(WIDTH-1){1'b0}}, s1_derr_q};
        end
    end

    // ------------------------------------------------------------------
    // Remaining DRAM_DELAY-1 return stages
    // ------------------------------------------------------------------
    resp_t resp_out;

    generate
        if (DRAM_DELAY > 1) begin : g_pipe
            resp_t pipe_q [DRAM_DELAY-1];
            resp_t pipe_d [DRAM_DELAY-1];

            // Shift the resolved return down the delay line.
            always_comb begin
                pipe_d[0] = s1_resp;
                for (int i = 1; i < DRAM_DELAY-1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Delay line registers; reset empties every slot.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DRAM_DELAY-1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DRAM_DELAY-1; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign resp_out = pipe_q[DRAM_DELAY-2];
        end else begin : g_direct
            assign resp_out = s1_resp;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.doutA = resp_out.data;
    assign bus.dvldA = resp_out.vld;
    assign bus.fwrdA = resp_out.fwd;
    assign bus.serrA = resp_out.serr;
    assign bus.derrA = resp_out.derr;
    assign bus.padrA = resp_out.padr;
    assign bus.busyA = busy_q;
    assign bus.collA = coll_q;

endmodule

// File: tb/tb_mt_1rw_bank_resp.sv
// Bench for mt_1rw_bank_resp: directed table, hand-written reset/boundary
// sequences, then randomized traffic against a behavioural bank model.
module tb_mt_1rw_bank_resp;
    localparam int WIDTH      = 32;
    localparam int NUMVROW    = 1000;
    localparam int BITVROW    = 10;
    localparam int BITPADR    = 14;
    localparam int BITPBNK    = 4;
    localparam int DRAM_DELAY = 2;
    localparam int REFR_CYC   = 4;
    localparam int NV         = 43;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mt_1rw_bank_resp_if #(
        .WIDTH(WIDTH), .BITVROW(BITVROW), .BITPADR(BITPADR), .BITPBNK(BITPBNK)
    ) bus ();

    mt_1rw_bank_resp #(
        .WIDTH(WIDTH), .NUMVROW(NUMVROW), .BITVROW(BITVROW), .BITPADR(BITPADR),
        .BITPBNK(BITPBNK), .DRAM_DELAY(DRAM_DELAY), .REFR_CYC(REFR_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural bank model ----------------
    // Memory is updated at acceptance; a read returns the latest accepted
    // write to its row, flagged as forwarded when that write was accepted in
    // the immediately preceding cycle.
    typedef struct {
        bit          vld;
        bit          known;
        logic [31:0] data;
        bit          fwd;
        bit          serr;
        bit          derr;
        int          padr;
    } ret_t;

    ret_t        exp_m [int];
    logic [31:0] mem_m   [NUMVROW];
    bit          known_m [NUMVROW];
    bit          serr_m  [NUMVROW];
    bit          derr_m  [NUMVROW];
    int          busy_left = 0;
    bit          coll_m    = 0;
    bit          last_wr   = 0;
    int          last_addr = 0;

    task automatic model_reset();
        exp_m.delete();
        for (int i = 0; i < NUMVROW; i++) begin
            known_m[i] = 0;
            serr_m[i]  = 0;
            derr_m[i]  = 0;
        end
        busy_left = 0;
        coll_m    = 0;
        last_wr   = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance.
    task automatic cycle(input bit rd, input bit wr, input int addr, input logic [31:0] din,
                         input bit refr, input bit is, input bit id);
        ret_t e;
        ret_t r;
        bit   busy, rs, acc, viol;
        bus.readA  = rd;
        bus.writeA = wr;
        bus.addrA  = BITVROW'(addr);
        bus.dinA   = din;
        bus.refrB  = refr;
        bus.inj_s  = is;
        bus.inj_d  = id;
        e = '{vld: 0, known: 1, data: 32'h0, fwd: 0, serr: 0, derr: 0, padr: 0};
        if (exp_m.exists(cyc)) begin
            e = exp_m[cyc];
            exp_m.delete(cyc);
        end
        chk("m_dvld", 32'(bus.dvldA), 32'(e.vld));
        if (e.known) chk("m_dout", bus.doutA, e.data);
        chk("m_fwrd", 32'(bus.fwrdA), 32'(e.fwd));
        chk("m_serr", 32'(bus.serrA), 32'(e.serr));
        chk("m_derr", 32'(bus.derrA), 32'(e.derr));
        chk("m_padr", 32'(bus.padrA), 32'(e.padr));
        chk("m_busy", 32'(bus.busyA), 32'(busy_left > 0));
        chk("m_coll", 32'(bus.collA), 32'(coll_m));

        busy = busy_left > 0;
        rs   = refr && !busy;
        acc  = rd || wr;
        viol = (rd && wr) || (acc && (busy || rs)) || (acc && addr >= NUMVROW);
        if (viol) coll_m = 1;
        if (rd && !viol) begin
            r.vld   = 1;
            r.known = known_m[addr];
            r.data  = mem_m[addr];
            r.fwd   = last_wr && (last_addr == addr);
            r.derr  = derr_m[addr];
            r.serr  = serr_m[addr] && !r.derr;
            if (r.derr) r.data = r.data ^ 32'h1;
            r.padr  = addr;
            exp_m[cyc + DRAM_DELAY] = r;
        end
        if (wr && !viol) begin
            mem_m[addr]   = din;
            known_m[addr] = 1;
            serr_m[addr]  = is;
            derr_m[addr]  = id;
        end
        last_wr   = wr && !viol;
        last_addr = addr;
        if (busy) busy_left--;
        else if (rs) busy_left = REFR_CYC;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dvld"}, 32'(bus.dvldA), 32'h0);
        chk({tag, "_dout"}, bus.doutA, 32'h0);
        chk({tag, "_fwrd"}, 32'(bus.fwrdA), 32'h0);
        chk({tag, "_serr"}, 32'(bus.serrA), 32'h0);
        chk({tag, "_derr"}, 32'(bus.derrA), 32'h0);
        chk({tag, "_padr"}, 32'(bus.padrA), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busyA), 32'h0);
        chk({tag, "_coll"}, 32'(bus.collA), 32'h0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        bus.readA = 0; bus.writeA = 0; bus.addrA = '0; bus.dinA = '0;
        bus.refrB = 0; bus.inj_s = 0; bus.inj_d = 0;
        #2;
        rst = 1'b0;
        #1;
        chk_zero("rst_now");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 1'b1;
        model_reset();
        cyc += 2;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rd, wr;
        int          addr;
        logic [31:0] din;
        bit          refr, is, id;
        bit          e_vld;
        logic [31:0] e_dout;
        bit          e_fwd, e_serr, e_derr;
        int          e_padr;
        bit          e_busy, e_coll;
    } vec_t;

    vec_t tbl [NV];

    task automatic set_in(input int i, input bit rd, input bit wr, input int addr,
                          input logic [31:0] din, input bit refr, input bit is, input bit id);
        tbl[i].rd = rd; tbl[i].wr = wr; tbl[i].addr = addr; tbl[i].din = din;
        tbl[i].refr = refr; tbl[i].is = is; tbl[i].id = id;
    endtask

    task automatic set_out(input int i, input logic [31:0] dout, input bit fwd,
                           input bit serr, input bit derr, input int padr);
        tbl[i].e_vld = 1; tbl[i].e_dout = dout; tbl[i].e_fwd = fwd;
        tbl[i].e_serr = serr; tbl[i].e_derr = derr; tbl[i].e_padr = padr;
    endtask

    initial begin
        bus.readA = 0; bus.writeA = 0; bus.addrA = '0; bus.dinA = '0;
        bus.refrB = 0; bus.inj_s = 0; bus.inj_d = 0;

        for (int i = 0; i < NV; i++) begin
            tbl[i] = '{rd: 0, wr: 0, addr: 0, din: 32'h0, refr: 0, is: 0, id: 0,
                       e_vld: 0, e_dout: 32'h0, e_fwd: 0, e_serr: 0, e_derr: 0,
                       e_padr: 0, e_busy: 0, e_coll: 0};
        end
        // write then late read: array path
        set_in(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        set_in(3, 1, 0, 5, 32'h0, 0, 0, 0);
        set_out(5, 32'hDEADBEEF, 0, 0, 0, 5);
        // write then next-cycle read: forwarded
        set_in(6, 0, 1, 7, 32'h12345678, 0, 0, 0);
        set_in(7, 1, 0, 7, 32'h0, 0, 0, 0);
        set_out(9, 32'h12345678, 1, 0, 0, 7);
        // single-error injection, clearing rewrite, double-error injection
        set_in(10, 0, 1, 9, 32'hAAAA5555, 0, 1, 0);
        set_in(12, 1, 0, 9, 32'h0, 0, 0, 0);
        set_out(14, 32'hAAAA5555, 0, 1, 0, 9);
        set_in(15, 0, 1, 9, 32'h0F0F0F0F, 0, 0, 0);
        set_in(16, 1, 0, 9, 32'h0, 0, 0, 0);
        set_out(18, 32'h0F0F0F0F, 1, 0, 0, 9);
        set_in(19, 0, 1, 9, 32'h11111110, 0, 0, 1);
        set_in(21, 1, 0, 9, 32'h0, 0, 0, 0);
        set_out(23, 32'h11111111, 0, 0, 1, 9);
        set_in(24, 0, 1, 9, 32'h22222222, 0, 1, 1);
        set_in(25, 1, 0, 9, 32'h0, 0, 0, 0);
        set_out(27, 32'h22222223, 1, 0, 1, 9);
        // read & write together: both dropped, old contents survive
        set_in(28, 0, 1, 3, 32'h33333333, 0, 0, 0);
        set_in(30, 1, 1, 3, 32'h99999999, 0, 0, 0);
        set_in(32, 1, 0, 3, 32'h0, 0, 0, 0);
        set_out(34, 32'h33333333, 0, 0, 0, 3);
        for (int i = 31; i < NV; i++) tbl[i].e_coll = 1;
        // refresh: busy four cycles, read while busy dropped, refrB while busy ignored
        set_in(35, 0, 0, 0, 32'h0, 1, 0, 0);
        for (int i = 36; i <= 39; i++) tbl[i].e_busy = 1;
        set_in(37, 1, 0, 5, 32'h0, 0, 0, 0);
        set_in(38, 0, 0, 0, 32'h0, 1, 0, 0);
        set_in(40, 1, 0, 5, 32'h0, 0, 0, 0);
        set_out(42, 32'hDEADBEEF, 0, 0, 0, 5);

        // ---------------- power-on reset ----------------
        #2;
        rst = 1'b0;
        #1;
        chk_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            chk("t_dvld", 32'(bus.dvldA), 32'(tbl[i].e_vld));
            chk("t_dout", bus.doutA, tbl[i].e_dout);
            chk("t_fwrd", 32'(bus.fwrdA), 32'(tbl[i].e_fwd));
            chk("t_serr", 32'(bus.serrA), 32'(tbl[i].e_serr));
            chk("t_derr", 32'(bus.derrA), 32'(tbl[i].e_derr));
            chk("t_padr", 32'(bus.padrA), 32'(tbl[i].e_padr));
            chk("t_busy", 32'(bus.busyA), 32'(tbl[i].e_busy));
            chk("t_coll", 32'(bus.collA), 32'(tbl[i].e_coll));
            cycle(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din,
                  tbl[i].refr, tbl[i].is, tbl[i].id);
        end

        // ---------------- address boundary ----------------
        do_reset();
        cycle(0, 1, NUMVROW-1, 32'hCAFE0999, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0);
        cycle(1, 0, NUMVROW-1, 32'h0, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0);
        chk("bnd_vld", 32'(bus.dvldA), 32'h1);
        chk("bnd_padr", 32'(bus.padrA), 32'(NUMVROW-1));
        chk("bnd_coll0", 32'(bus.collA), 32'h0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0);
        cycle(1, 0, NUMVROW, 32'h0, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0);
        chk("bnd_coll1", 32'(bus.collA), 32'h1);
        cycle(0, 0, 0, 32'h0, 0, 0, 0);
        chk("bnd_drop", 32'(bus.dvldA), 32'h0);

        // ---------------- back-to-back reads, reset mid-stream ----------------
        do_reset();
        for (int i = 0; i < 8; i++) cycle(0, 1, i, 32'hB0B00000 + 32'(i), 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, i, 32'h0, 0, 0, 0);
        chk("b2b_vld", 32'(bus.dvldA), 32'h1);
        chk("b2b_dout", bus.doutA, 32'hB0B00003);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 32'h0, 0, 0, 0);

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 3000; n++) begin
            int op;
            int a;
            bit rd, wr, rf;
            op = $urandom_range(0, 99);
            a  = ($urandom_range(0, 19) == 0) ? $urandom_range(996, 1023) : $urandom_range(0, 15);
            rd = (op < 40) || (op >= 75 && op < 78);
            wr = (op >= 40 && op < 78);
            rf = ($urandom_range(0, 29) == 0);
            cycle(rd, wr, a, $urandom(), rf,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
            if (n % 250 == 249) do_reset();
        end
        for (int i = 0; i < DRAM_DELAY + 2; i++) cycle(0, 0, 0, 32'h0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
